// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand and result handshakes for the nibble-serial adder
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder built from one 4-bit slice, one nibble per cycle,
// carry held in a register between nibbles; valid/ready on both sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [4:0]       w_slice;
    // Operands shift right so the active nibble always sits in bits [3:0]
    assign w_slice = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_carry <= bus.cin;
                    r_state <= RUN;
                end
                RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_slice[4];
                    r_sum   <= {w_slice[3:0], r_sum[WIDTH-1:4]};
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_cnt   <= '0;
                        r_cout  <= w_slice[4];
                        r_ovf   <= r_a[3] ^ r_b[3] ^ w_slice[3] ^ w_slice[4];
                        r_state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and randomised checks of nibble_serial_adder at WIDTH 16 and 8,
// expected results queued at acceptance and compared at the output handshake.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [17:0] q16[$];
    logic [9:0]  q8[$];
    always #5 clk = ~clk;
    nibble_serial_adder_if #(.WIDTH(16)) if16();
    nibble_serial_adder_if #(.WIDTH(8))  if8();
    nibble_serial_adder #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(if16.slave));
    nibble_serial_adder #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8.slave));

    function automatic logic [17:0] m16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'b0, c};
        return {t[15:0], t[16], (a[15] == b[15]) && (t[15] != a[15])};
    endfunction

    function automatic logic [9:0] m8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'b0, c};
        return {t[7:0], t[8], (a[7] == b[7]) && (t[7] != a[7])};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [17:0] got, output int lat);
        if16.a = a;
        if16.b = b;
        if16.cin = c;
        if16.in_valid = 1'b1;
        q16.push_back(m16(a, b, c));
        tick;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            tick;
            lat++;
        end
        got = {if16.sum, if16.cout, if16.overflow};
        if16.out_ready = 1'b1;
        tick;
        if16.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
        checks++;
        if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow} !== {2'b10, 18'h0}) begin
            errors++;
            $display("FAIL reset16 got rdy=%b vld=%b sum=%h cout=%b ovf=%b exp rdy=1 vld=0 sum=0000 cout=0 ovf=0",
                     if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow);
        end
        checks++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout, if8.overflow} !== {2'b10, 10'h0}) begin
            errors++;
            $display("FAIL reset8 got rdy=%b vld=%b sum=%h exp rdy=1 vld=0 sum=00",
                     if8.in_ready, if8.out_valid, if8.sum);
        end
    endtask

    task automatic test_wrap;
        logic [17:0] got, exp;
        int lat;
        op16(16'hFFFF, 16'h0001, 1'b0, got, lat);
        exp = q16.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_model got=%h exp=%h", got, exp);
        end
        checks++;
        if (got !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_const got=%h exp=%h", got, {16'h0000, 1'b1, 1'b0});
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL wrap_latency got=%0d exp=4", lat);
        end
    endtask

    task automatic test_overflow;
        logic [17:0] got, exp;
        int lat;
        op16(16'h7FFF, 16'h0001, 1'b0, got, lat);
        exp = q16.pop_front();
        checks++;
        if (got !== exp || got !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pos got=%h exp=%h", got, {16'h8000, 1'b0, 1'b1});
        end
        op16(16'h8000, 16'h8000, 1'b0, got, lat);
        exp = q16.pop_front();
        checks++;
        if (got !== exp || got !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_neg got=%h exp=%h", got, {16'h0000, 1'b1, 1'b1});
        end
    endtask

    task automatic test_change_during_run;
        logic [17:0] got, exp;
        int lat;
        if16.a = 16'h1234;
        if16.b = 16'h4321;
        if16.cin = 1'b1;
        if16.in_valid = 1'b1;
        q16.push_back(m16(16'h1234, 16'h4321, 1'b1));
        tick;
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            if16.a = 16'($urandom);
            if16.b = 16'($urandom);
            if16.cin = 1'($urandom);
            tick;
            lat++;
        end
        if16.in_valid = 1'b0;
        got = {if16.sum, if16.cout, if16.overflow};
        exp = q16.pop_front();
        checks++;
        if (got !== exp || got !== {16'h5556, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL run_change got=%h exp=%h", got, {16'h5556, 1'b0, 1'b0});
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL run_change_latency got=%0d exp=4", lat);
        end
        if16.out_ready = 1'b1;
        tick;
        if16.out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [17:0] got, exp;
        logic [15:0] s0;
        int lat;
        if16.a = 16'hA5A5;
        if16.b = 16'h1111;
        if16.cin = 1'b0;
        if16.in_valid = 1'b1;
        q16.push_back(m16(16'hA5A5, 16'h1111, 1'b0));
        tick;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 20) begin
            tick;
            lat++;
        end
        s0 = if16.sum;
        if16.in_valid = 1'b1;
        if16.a = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({if16.out_valid, if16.in_ready, if16.sum} !== {2'b10, s0}) begin
                errors++;
                $display("FAIL hold_%0d got vld=%b rdy=%b sum=%h exp vld=1 rdy=0 sum=%h",
                         i, if16.out_valid, if16.in_ready, if16.sum, s0);
            end
        end
        if16.in_valid = 1'b0;
        got = {if16.sum, if16.cout, if16.overflow};
        exp = q16.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL hold_result got=%h exp=%h", got, exp);
        end
        if16.out_ready = 1'b1;
        tick;
        if16.out_ready = 1'b0;
        checks++;
        if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL release got vld=%b rdy=%b exp vld=0 rdy=1", if16.out_valid, if16.in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [17:0] got, exp;
        int lat;
        int seen;
        if16.a = 16'hFFFF;
        if16.b = 16'h0001;
        if16.cin = 1'b0;
        if16.in_valid = 1'b1;
        tick;
        if16.in_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        checks++;
        if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow} !== {2'b10, 18'h0}) begin
            errors++;
            $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h cout=%b ovf=%b exp rdy=1 vld=0 sum=0000",
                     if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow);
        end
        tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (if16.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_valid got=%0d exp=0", seen);
        end
        op16(16'h0005, 16'h0003, 1'b0, got, lat);
        exp = q16.pop_front();
        checks++;
        if (got !== exp || got !== {16'h0008, 2'b00} || lat !== 4) begin
            errors++;
            $display("FAIL after_reset got=%h lat=%0d exp=%h lat=4", got, lat, {16'h0008, 2'b00});
        end
        checks++;
        op16(16'h0000, 16'h0000, 1'b1, got, lat);
        exp = q16.pop_front();
        if (got !== exp || got !== {16'h0001, 2'b00}) begin
            errors++;
            $display("FAIL cin_only got=%h exp=%h", got, {16'h0001, 2'b00});
        end
    endtask

    task automatic rand16;
        int sent = 0;
        int rcvd = 0;
        fork
            begin
                int c = 0;
                while (sent < 1000 && c < 30000) begin
                    logic rdy;
                    if16.in_valid = ($urandom_range(3) != 0);
                    if16.a = 16'($urandom);
                    if16.b = 16'($urandom);
                    if16.cin = 1'($urandom);
                    rdy = if16.in_ready;
                    tick;
                    c++;
                    if (if16.in_valid && rdy) begin
                        q16.push_back(m16(if16.a, if16.b, if16.cin));
                        sent++;
                    end
                end
                if16.in_valid = 1'b0;
            end
            begin
                int c = 0;
                while (rcvd < 1000 && c < 30000) begin
                    logic v;
                    logic [17:0] g, e;
                    if16.out_ready = ($urandom_range(3) != 0);
                    v = if16.out_valid;
                    g = {if16.sum, if16.cout, if16.overflow};
                    tick;
                    c++;
                    if (v && if16.out_ready) begin
                        checks++;
                        rcvd++;
                        if (q16.size() == 0) begin
                            errors++;
                            $display("FAIL rand16_extra got=%h exp=none", g);
                        end else begin
                            e = q16.pop_front();
                            if (g !== e) begin
                                errors++;
                                $display("FAIL rand16 got=%h exp=%h", g, e);
                            end
                        end
                    end
                end
                if16.out_ready = 1'b0;
            end
        join
        checks++;
        if (rcvd !== 1000 || q16.size() != 0) begin
            errors++;
            $display("FAIL rand16_count got rcvd=%0d left=%0d exp rcvd=1000 left=0", rcvd, q16.size());
        end
    endtask

    task automatic rand8;
        int sent = 0;
        int rcvd = 0;
        fork
            begin
                int c = 0;
                while (sent < 1000 && c < 30000) begin
                    logic rdy;
                    if8.in_valid = ($urandom_range(3) != 0);
                    if8.a = 8'($urandom);
                    if8.b = 8'($urandom);
                    if8.cin = 1'($urandom);
                    rdy = if8.in_ready;
                    tick;
                    c++;
                    if (if8.in_valid && rdy) begin
                        q8.push_back(m8(if8.a, if8.b, if8.cin));
                        sent++;
                    end
                end
                if8.in_valid = 1'b0;
            end
            begin
                int c = 0;
                while (rcvd < 1000 && c < 30000) begin
                    logic v;
                    logic [9:0] g, e;
                    if8.out_ready = ($urandom_range(3) != 0);
                    v = if8.out_valid;
                    g = {if8.sum, if8.cout, if8.overflow};
                    tick;
                    c++;
                    if (v && if8.out_ready) begin
                        checks++;
                        rcvd++;
                        if (q8.size() == 0) begin
                            errors++;
                            $display("FAIL rand8_extra got=%h exp=none", g);
                        end else begin
                            e = q8.pop_front();
                            if (g !== e) begin
                                errors++;
                                $display("FAIL rand8 got=%h exp=%h", g, e);
                            end
                        end
                    end
                end
                if8.out_ready = 1'b0;
            end
        join
        checks++;
        if (rcvd !== 1000 || q8.size() != 0) begin
            errors++;
            $display("FAIL rand8_count got rcvd=%0d left=%0d exp rcvd=1000 left=0", rcvd, q8.size());
        end
    endtask

    task automatic test_random;
        fork
            rand16;
            rand8;
        join
    endtask

    initial begin
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.cin = 1'b0;
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.cin = 1'b0;
        test_reset;
        test_wrap;
        test_overflow;
        test_change_during_run;
        test_backpressure;
        test_reset_mid_run;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
